// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer; a beat accepted at edge N appears on out_* after edge N.
// in_ready and out_data come straight from flops; optional stall/bubble counters behind PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}},
  parameter int unsigned      CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] bubble_cycles
);

  // State encoding is {main_valid, skid_valid}; the valid bits are the state flops.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_BUSY  = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_main_from_skid;

  assign in_ready  = ~r_state[0];
  assign out_valid = r_state[1];
  assign out_data  = r_main_data;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      // Offered beat is dropped; data flops keep their contents.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_drain) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = S_BUSY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_data <= RESET_DATA;
      r_skid_data <= '0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_main_from_skid ? r_skid_data : in_data;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (!out_valid && out_ready && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cycles  = r_stall_cnt;
  assign bubble_cycles = r_bubble_cnt;
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid: reset, streaming, backpressure, flush, async reset, counters.
module tb_pipe_stage_skid;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [WIDTH-1:0] RST_DATA = 32'hDEAD_BEEF;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] bubble_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RST_DATA),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_data !== RST_DATA) begin n_fail++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RST_DATA); end
    n_checks++;
    if (stall_cycles !== 4'd0 || bubble_cycles !== 4'd0) begin
      n_fail++; $display("FAIL reset_counters got=%h/%h exp=0/0", stall_cycles, bubble_cycles);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, in_ready); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
        n_fail++; $display("FAIL stream_out beat=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, i);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h8) begin
      n_fail++; $display("FAIL stream_idle_hold got=%b/%h exp=0/00000008", out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data   = 32'hB;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_backpressure();
    fill_ab();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
      n_fail++; $display("FAIL bp_full got rdy=%b vld=%b dat=%h exp rdy=0 vld=1 dat=a", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hB) begin
      n_fail++; $display("FAIL bp_drain1 got rdy=%b vld=%b dat=%h exp rdy=1 vld=1 dat=b", in_ready, out_valid, out_data);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hB) begin
      n_fail++; $display("FAIL bp_drain2 got vld=%b dat=%h exp vld=0 dat=b", out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    fill_ab();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hA) begin
      n_fail++; $display("FAIL flush_full got vld=%b rdy=%b dat=%h exp vld=0 rdy=1 dat=a", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_data === 32'hC) begin
        n_fail++; $display("FAIL flush_no_ghost cyc=%0d got vld=%b dat=%h exp vld=0", i, out_valid, out_data);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    fill_ab();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== RST_DATA || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got vld=%b dat=%h rdy=%b exp vld=0 dat=%h rdy=1", out_valid, out_data, in_ready, RST_DATA);
    end
    step();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55) begin
      n_fail++; $display("FAIL async_after got vld=%b dat=%h exp vld=1 dat=55", out_valid, out_data);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_d;
    int               prints = 0;
    bit               acc;
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = $urandom;
      n_checks++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        n_fail++;
        if (prints < 20) begin
          prints++;
          $display("FAIL rand_occupancy cyc=%0d got rdy=%b vld=%b exp occupancy=%0d", cyc, in_ready, out_valid, q.size());
        end
      end
      acc = in_valid && (q.size() < 2) && !flush;
      if (out_ready && q.size() > 0) begin
        exp_d = q.pop_front();
        n_checks++;
        if (out_data !== exp_d) begin
          n_fail++;
          if (prints < 20) begin
            prints++;
            $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_d);
          end
        end
      end
      if (flush) q.delete();
      else if (acc) q.push_back(in_data);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_perf();
    rst = 1'b0;
    step();
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
`ifdef PIPE_STAGE_SKID_PERF_EN
    n_checks++;
    if (stall_cycles !== 4'd5) begin n_fail++; $display("FAIL perf_stall5 got=%h exp=5", stall_cycles); end
`endif
    for (int i = 0; i < 15; i++) step();
`ifdef PIPE_STAGE_SKID_PERF_EN
    n_checks++;
    if (stall_cycles !== 4'hF) begin n_fail++; $display("FAIL perf_stall_sat got=%h exp=f", stall_cycles); end
`else
    n_checks++;
    if (stall_cycles !== 4'h0) begin n_fail++; $display("FAIL perf_stall_off got=%h exp=0", stall_cycles); end
`endif
    flush = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
`ifdef PIPE_STAGE_SKID_PERF_EN
    n_checks++;
    if (stall_cycles !== 4'hF || bubble_cycles !== 4'd3) begin
      n_fail++; $display("FAIL perf_after_flush got=%h/%h exp=f/3", stall_cycles, bubble_cycles);
    end
`else
    n_checks++;
    if (bubble_cycles !== 4'h0) begin n_fail++; $display("FAIL perf_bubble_off got=%h exp=0", bubble_cycles); end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_async_reset();
    test_random();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
